risc_v_mike_imem_loader: RTL and testbench

//  Boot-time controller that fills instruction memory from a UART byte stream, then releases the core.

---
 rtl/risc_v_mike_pkg.sv | 23 ++
 rtl/risc_v_mike_byte_packer.sv | 40 ++++
 rtl/risc_v_mike_imem_loader.sv | 159 +++++++++++++++
 tb/tb_risc_v_mike_imem_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike boot-time imem loader.
// Holds the loader state encoding, the default frame sync byte and a
// helper that classifies which states count as "frame in progress".
package risc_v_mike_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } imem_ldr_state_e;

    localparam logic [7:0] IMEM_LDR_SYNC_DEFAULT = 8'hA5;

    // A frame is in progress in every state except the three resting ones.
    function automatic logic ldr_busy(input imem_ldr_state_e s);
        return !((s == IDLE) || (s == DONE) || (s == ERR));
    endfunction

endpackage

// File: rtl/risc_v_mike_byte_packer.sv
// Packs four consecutive bytes, LSB first, into a 32-bit little-endian word.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         drop any partial word and restart at byte 0
//   byte_valid    byte_data is accepted this cycle
//   byte_data     incoming byte
//   word_valid_c  combinational: this accepted byte completes a word
//   word_c        combinational: completed word (valid with word_valid_c)
module risc_v_mike_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid_c,
    output logic [31:0] word_c
);

    logic [1:0]  byte_cnt;
    logic [23:0] partial;

    // The 4th byte is not stored; it is merged on the fly so the caller can
    // register the finished word in the same cycle it is accepted.
    assign word_valid_c = byte_valid && (byte_cnt == 2'd3);
    assign word_c       = {byte_data, partial};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= 2'd0;
            partial  <= 24'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            partial  <= 24'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            partial  <= {byte_data, partial[23:8]};
        end
    end

endmodule

// File: rtl/risc_v_mike_imem_loader.sv
// Boot-time loader: parses a framed program image from a UART byte stream,
// writes it word by word into imem, and releases the core when finished.
// Frame: SYNC, CNT_LO, CNT_HI, then CNT words of 4 bytes, LSB first.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte (state CHK); without it the last data word ends the frame.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rx_data, rx_valid        byte stream from the UART receiver
//   boot_skip                in IDLE, release the core without loading
//   imem_we/addr/wdata       imem word write port
//   core_rst_n               core reset, held low until load completes
//   busy, done, error        loader status (done/error sticky until reset)
module risc_v_mike_imem_loader
    import risc_v_mike_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_WORD  = 2,
    parameter logic [7:0]  SYNC_BYTE  = IMEM_LDR_SYNC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  boot_skip,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MAX_WORDS = (2 ** ADDR_WIDTH) - BASE_WORD;

    imem_ldr_state_e state;
    logic [7:0]      cnt_lo;
    logic [15:0]     n_words;
    logic [15:0]     word_cnt;
    logic [15:0]     n_rx_c;
    logic            byte_in_c;
    logic            pack_clear_c;
    logic            word_valid_c;
    logic [31:0]     word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign n_rx_c       = {rx_data, cnt_lo};
    assign byte_in_c    = rx_valid && (state == DATA);
    assign pack_clear_c = rx_valid && (state == IDLE) && (rx_data == SYNC_BYTE);

    risc_v_mike_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (pack_clear_c),
        .byte_valid   (byte_in_c),
        .byte_data    (rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Status outputs follow the state with one cycle of lag, so done and
    // core_rst_n rise the cycle after the final imem write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt_lo     <= 8'd0;
            n_words    <= 16'd0;
            word_cnt   <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            imem_we    <= 1'b0;
            busy       <= ldr_busy(state);
            done       <= (state == DONE);
            core_rst_n <= (state == DONE);
            error      <= (state == ERR);

            case (state)
                IDLE: begin
                    // A received byte takes priority over boot_skip.
                    if (rx_valid) begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= CNT_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum  <= 8'd0;
`endif
                        end
                    end else if (boot_skip) begin
                        state <= DONE;
                    end
                end
                CNT_LO: begin
                    if (rx_valid) begin
                        cnt_lo <= rx_data;
                        state  <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (rx_valid) begin
                        n_words  <= n_rx_c;
                        word_cnt <= 16'd0;
                        if (n_rx_c == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CHK;
`else
                            state <= DONE;
`endif
                        end else if (32'(n_rx_c) > MAX_WORDS) begin
                            state <= ERR;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (byte_in_c) begin
                        csum <= csum ^ rx_data;
                    end
`endif
                    if (word_valid_c) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ADDR_WIDTH'(BASE_WORD) + ADDR_WIDTH'(word_cnt);
                        imem_wdata <= word_c;
                        word_cnt   <= word_cnt + 16'd1;
                        if ((word_cnt + 16'd1) == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CHK;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (rx_valid) begin
                        state <= (rx_data == csum) ? DONE : ERR;
                    end
                end
`endif
                DONE: state <= DONE;
                ERR:  state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_v_mike_imem_loader.sv
// Scoreboard bench for risc_v_mike_imem_loader (default parameters).
// Stimulus pushes expected imem writes into a queue; a monitor pops and
// compares on every imem_we. Status outputs are checked at fixed points.
module tb_risc_v_mike_imem_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        boot_skip;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    int   n_checks = 0;
    int   n_pass   = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [7:0] tx_q[$];

    risc_v_mike_imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .boot_skip  (boot_skip),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst === 1'b1 && imem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (imem_addr === mon_e.addr && imem_wdata === mon_e.data) n_pass++;
                else $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                              imem_addr, imem_wdata, mon_e.addr, mon_e.data);
            end
        end
    end

    task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Drive tx_q one byte per cycle; gap inserts an idle cycle before each byte.
    // Returns at the negedge just after the last byte was accepted.
    task automatic send(input bit gap);
        foreach (tx_q[i]) begin
            if (gap) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
            rx_data  = tx_q[i];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_q_empty(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        boot_skip = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        boot_skip = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_imem_addr",  32'(imem_addr),  32'd0);
        check("rst_imem_wdata", imem_wdata,      32'd0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_error",      32'(error),      32'd0);

        // Idle for 1000 cycles with no bytes: core stays held, nothing written.
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_core_rst_n", 32'(core_rst_n), 32'd0);
        check("idle_busy",       32'(busy),       32'd0);
        check("idle_done",       32'(done),       32'd0);

        // Two-word frame with idle gaps between bytes.
        expect_wr(8'd2, 32'h00200093);
        expect_wr(8'd3, 32'h00400113);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'h13, 8'h01, 8'h40, 8'h00};
        send(1'b1);
        check("two_word_we_last",  32'(imem_we), 32'd1);
        check("two_word_done_lag", 32'(done),    32'd0);
        @(negedge clk);
        check("two_word_done",       32'(done),       32'd1);
        check("two_word_core_rst_n", 32'(core_rst_n), 32'd1);
        check("two_word_busy",       32'(busy),       32'd0);
        check_q_empty("two_word_all_written");
        // Bytes after DONE are ignored.
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send(1'b0);
        repeat (2) @(negedge clk);
        check("done_sticky", 32'(done), 32'd1);

        // Back-to-back bytes with leading garbage before the sync byte.
        do_reset();
        expect_wr(8'd2, 32'hFF9FF06F);
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h6F, 8'hF0, 8'h9F, 8'hFF};
        send(1'b0);
        @(negedge clk);
        check("b2b_done", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        check("b2b_addr_hold",  32'(imem_addr), 32'd2);
        check("b2b_wdata_hold", imem_wdata,     32'hFF9FF06F);
        check_q_empty("b2b_all_written");

        // N = 255 exceeds the 254 available words.
        do_reset();
        tx_q = '{8'hA5, 8'hFF, 8'h00};
        send(1'b0);
        @(negedge clk);
        check("ovf_error",      32'(error),      32'd1);
        check("ovf_core_rst_n", 32'(core_rst_n), 32'd0);
        check("ovf_busy",       32'(busy),       32'd0);
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send(1'b0);
        @(negedge clk);
        check("ovf_error_sticky", 32'(error), 32'd1);

        // N = 254 is the largest legal count.
        do_reset();
        tx_q = '{8'hA5, 8'hFE, 8'h00};
        send(1'b0);
        @(negedge clk);
        check("max_busy",  32'(busy),  32'd1);
        check("max_error", 32'(error), 32'd0);

        // Reset in the middle of word 2, then a fresh one-word frame.
        do_reset();
        expect_wr(8'd2, 32'h44332211);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send(1'b0);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd1);
        do_reset();
        check("abort_core_rst_n", 32'(core_rst_n), 32'd0);
        expect_wr(8'd2, 32'h12345678);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send(1'b0);
        @(negedge clk);
        check("abort_new_done", 32'(done), 32'd1);
        check_q_empty("abort_all_written");

        // Zero-length frame completes without writing.
        do_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
`else
        tx_q = '{8'hA5, 8'h00, 8'h00};
`endif
        send(1'b0);
        @(negedge clk);
        check("zero_done",       32'(done),       32'd1);
        check("zero_core_rst_n", 32'(core_rst_n), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Correct checksum: 93^00^20^00 = B3.
        do_reset();
        expect_wr(8'd2, 32'h00200093);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hB3};
        send(1'b0);
        @(negedge clk);
        check("csum_ok_done",  32'(done),  32'd1);
        check("csum_ok_error", 32'(error), 32'd0);
        // Wrong checksum.
        do_reset();
        expect_wr(8'd2, 32'h00200093);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'h00};
        send(1'b0);
        @(negedge clk);
        check("csum_bad_error",      32'(error),      32'd1);
        check("csum_bad_core_rst_n", 32'(core_rst_n), 32'd0);
        check("csum_bad_done",       32'(done),       32'd0);
`endif

        // boot_skip releases the core directly from IDLE.
        do_reset();
        boot_skip = 1'b1;
        @(negedge clk);
        boot_skip = 1'b0;
        @(negedge clk);
        check("skip_done",       32'(done),       32'd1);
        check("skip_core_rst_n", 32'(core_rst_n), 32'd1);

        repeat (2) @(negedge clk);
        check_q_empty("final_all_written");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
